// File: rtl/aes_round_sequencer_if.sv
// Command/strobe bundle between the AES wrapper, the round sequencer and the round datapath.
// The sequencer connects through the slave modport; the wrapper side uses master.
interface aes_round_sequencer_if;
    logic       start_valid;
    logic       start_ready;
    logic       key_ready;
    logic       load_sel;
    logic       round_en;
    logic       final_sel;
    logic [3:0] key_sel;
    logic [3:0] round_num;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] job_cnt;

    modport master (
        output start_valid, key_ready, out_ready,
        input  start_ready, load_sel, round_en, final_sel,
        input  key_sel, round_num, busy, out_valid, job_cnt
    );

    modport slave (
        input  start_valid, key_ready, out_ready,
        output start_ready, load_sel, round_en, final_sel,
        output key_sel, round_num, busy, out_valid, job_cnt
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES-256 datapath: initial AddRoundKey, full rounds, final round.
// Define AES_SEQ_BACK2BACK_EN to let a new job be accepted in the same cycle the result is taken.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS    = 14,
    parameter int CYC_PER_ROUND = 2
) (
    input logic                  clk,
    input logic                  reset,
    aes_round_sequencer_if.slave seq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYWAIT,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_HOLD
    } state_t;

    localparam logic [1:0] LAST_PHASE  = 2'(CYC_PER_ROUND - 1);
    localparam logic [3:0] LAST_ROUND  = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] FINAL_ROUND = 4'(NUM_ROUNDS);

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] job_cnt_q, job_cnt_d;
    logic       accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            round_q   <= 4'd0;
            phase_q   <= 2'd0;
            job_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            phase_q   <= phase_d;
            job_cnt_q <= job_cnt_d;
        end
    end

    // Only the back-to-back build lets out_ready reach start_ready combinationally.
    always_comb begin
        seq.start_ready = (state_q == S_IDLE);
`ifdef AES_SEQ_BACK2BACK_EN
        if (state_q == S_HOLD && seq.out_ready)
            seq.start_ready = 1'b1;
`endif
    end

    assign accept = seq.start_valid & seq.start_ready;

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        phase_d   = phase_q;
        job_cnt_d = job_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = seq.key_ready ? S_LOAD : S_KEYWAIT;
            end
            S_KEYWAIT: begin
                if (seq.key_ready)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_ROUND;
                round_d = 4'd1;
                phase_d = 2'd0;
            end
            S_ROUND: begin
                if (phase_q == LAST_PHASE) begin
                    phase_d = 2'd0;
                    if (round_q == LAST_ROUND)
                        state_d = S_FINAL;
                    else
                        round_d = round_q + 4'd1;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            S_FINAL: begin
                if (phase_q == LAST_PHASE) begin
                    state_d   = S_HOLD;
                    phase_d   = 2'd0;
                    round_d   = 4'd0;
                    job_cnt_d = job_cnt_q + 8'd1;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            S_HOLD: begin
                if (seq.out_ready) begin
`ifdef AES_SEQ_BACK2BACK_EN
                    if (accept)
                        state_d = seq.key_ready ? S_LOAD : S_KEYWAIT;
                    else
                        state_d = S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The final round has its own unit, so round_en stays low there and the strobes never overlap.
    always_comb begin
        seq.load_sel  = 1'b0;
        seq.round_en  = 1'b0;
        seq.final_sel = 1'b0;
        seq.key_sel   = 4'd0;
        seq.round_num = 4'd0;
        seq.out_valid = 1'b0;
        seq.busy      = (state_q != S_IDLE);
        case (state_q)
            S_LOAD: seq.load_sel = 1'b1;
            S_ROUND: begin
                seq.round_en  = (phase_q == 2'd0);
                seq.key_sel   = round_q;
                seq.round_num = round_q;
            end
            S_FINAL: begin
                seq.final_sel = 1'b1;
                seq.key_sel   = FINAL_ROUND;
                seq.round_num = FINAL_ROUND;
            end
            S_HOLD:  seq.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign seq.job_cnt = job_cnt_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized self-checking bench for aes_round_sequencer against a cycle-offset model of one job.
module tb_aes_round_sequencer;

    localparam int NR         = 14;
    localparam int CPR        = 2;
    localparam int ACTIVE_LEN = 1 + NR * CPR;
`ifdef AES_SEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef struct packed {
        logic       load;
        logic       ren;
        logic       fin;
        logic [3:0] ksel;
        logic [3:0] rnum;
        logic       busy;
        logic       ov;
        logic       sr;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   exp_jobs = 0;
    obs_t trace_q[$];

    aes_round_sequencer_if bus();

    aes_round_sequencer #(.NUM_ROUNDS(NR), .CYC_PER_ROUND(CPR)) dut (
        .clk   (clk),
        .reset (reset),
        .seq   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t sample();
        obs_t o;
        o.load = bus.load_sel;
        o.ren  = bus.round_en;
        o.fin  = bus.final_sel;
        o.ksel = bus.key_sel;
        o.rnum = bus.round_num;
        o.busy = bus.busy;
        o.ov   = bus.out_valid;
        o.sr   = bus.start_ready;
        return o;
    endfunction

    function automatic obs_t idle_exp();
        obs_t e;
        e    = '0;
        e.sr = 1'b1;
        return e;
    endfunction

    // Expected outputs d cycles after LOAD: round r occupies CPR cycles, round NR is the final round.
    function automatic obs_t expect_active(int d);
        obs_t e;
        int   r;
        e      = '0;
        e.busy = 1'b1;
        if (d == 0) begin
            e.load = 1'b1;
        end else if (d <= NR * CPR) begin
            r      = (d - 1) / CPR + 1;
            e.ksel = 4'(r);
            e.rnum = 4'(r);
            e.fin  = (r == NR);
            e.ren  = (r < NR) && ((d - 1) % CPR == 0);
        end else begin
            e.ov = 1'b1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        tests++;
        if (int'(bus.load_sel) + int'(bus.round_en) + int'(bus.final_sel) > 1) begin
            fails++;
            $display("[TB] FAIL strobe_exclusive at cycle %0d: load/round/final = %b%b%b, at most one high required",
                     cyc, bus.load_sel, bus.round_en, bus.final_sel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_accept(input bit kr);
        tick();
        bus.start_valid = 1'b1;
        bus.key_ready   = kr;
        tick();
        bus.start_valid = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            trace_q.push_back(sample());
            tick();
            bus.key_ready   = 1'($urandom_range(0, 1));
            bus.start_valid = 1'($urandom_range(0, 1));
        end
        bus.start_valid = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1;
        bus.start_valid = 1'b0;
        bus.key_ready   = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = sample();
        tests++;
        if (o !== idle_exp()) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", o, idle_exp());
        end
        tests++;
        if (bus.job_cnt !== 8'd0) begin
            fails++;
            $display("[TB] FAIL reset_job_cnt: got %0d expected 0", bus.job_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        obs_t o, e;
        int   gap = $urandom_range(1, 10);
        for (int i = 0; i < gap; i++) begin
            tick();
            @(negedge clk);
            o = sample();
            tests++;
            if (o !== idle_exp()) begin
                fails++;
                $display("[TB] FAIL basic_idle: got %h expected %h", o, idle_exp());
            end
        end
        drive_accept(1'b1);
        trace_q.delete();
        capture(ACTIVE_LEN);
        foreach (trace_q[d]) begin
            tests++;
            if (trace_q[d] !== expect_active(d)) begin
                fails++;
                $display("[TB] FAIL basic_seq d=%0d: got %h expected %h", d, trace_q[d], expect_active(d));
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        o    = sample();
        e    = expect_active(ACTIVE_LEN);
        e.sr = B2B;
        exp_jobs++;
        tests++;
        if (o !== e) begin
            fails++;
            $display("[TB] FAIL basic_hold: got %h expected %h", o, e);
        end
        tests++;
        if (bus.job_cnt !== 8'(exp_jobs)) begin
            fails++;
            $display("[TB] FAIL basic_job_cnt: got %0d expected %0d", bus.job_cnt, exp_jobs);
        end
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        o = sample();
        tests++;
        if (o !== idle_exp()) begin
            fails++;
            $display("[TB] FAIL basic_return_idle: got %h expected %h", o, idle_exp());
        end
    endtask

    task automatic test_keywait();
        obs_t o, e;
        int   delay = $urandom_range(2, 8);
        drive_accept(1'b0);
        e      = '0;
        e.busy = 1'b1;
        for (int i = 0; i < delay; i++) begin
            bus.key_ready   = (i == delay - 1);
            bus.start_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            o = sample();
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL keywait_hold i=%0d: got %h expected %h", i, o, e);
            end
            tick();
        end
        bus.start_valid = 1'b0;
        trace_q.delete();
        capture(ACTIVE_LEN);
        foreach (trace_q[d]) begin
            tests++;
            if (trace_q[d] !== expect_active(d)) begin
                fails++;
                $display("[TB] FAIL keywait_seq d=%0d: got %h expected %h", d, trace_q[d], expect_active(d));
            end
        end
        bus.out_ready = 1'b1;
        exp_jobs++;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.job_cnt !== 8'(exp_jobs)) begin
            fails++;
            $display("[TB] FAIL keywait_done: got out_valid=%b job_cnt=%0d expected 1 and %0d",
                     bus.out_valid, bus.job_cnt, exp_jobs);
        end
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        obs_t o, e;
        int   stall = $urandom_range(3, 9);
        drive_accept(1'b1);
        trace_q.delete();
        capture(ACTIVE_LEN);
        foreach (trace_q[d]) begin
            tests++;
            if (trace_q[d] !== expect_active(d)) begin
                fails++;
                $display("[TB] FAIL stall_seq d=%0d: got %h expected %h", d, trace_q[d], expect_active(d));
            end
        end
        exp_jobs++;
        e = expect_active(ACTIVE_LEN);
        for (int i = 0; i < stall; i++) begin
            bus.out_ready   = 1'b0;
            bus.start_valid = 1'b1;
            @(negedge clk);
            o = sample();
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL stall_hold i=%0d: got %h expected %h", i, o, e);
            end
            tick();
        end
        bus.start_valid = 1'b0;
        bus.out_ready   = 1'b1;
        @(negedge clk);
        o    = sample();
        e.sr = B2B;
        tests++;
        if (o !== e) begin
            fails++;
            $display("[TB] FAIL stall_release: got %h expected %h", o, e);
        end
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        o = sample();
        tests++;
        if (o !== idle_exp() || bus.job_cnt !== 8'(exp_jobs)) begin
            fails++;
            $display("[TB] FAIL stall_idle: got %h cnt %0d expected %h cnt %0d",
                     o, bus.job_cnt, idle_exp(), exp_jobs);
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        int   depth = 1 + 5 * CPR + $urandom_range(0, CPR - 1);
        drive_accept(1'b1);
        trace_q.delete();
        capture(depth);
        tests++;
        if (bus.round_num !== 4'd6) begin
            fails++;
            $display("[TB] FAIL areset_setup: got round_num %0d expected 6", bus.round_num);
        end
        #2;
        reset = 1'b1;
        #1;
        o = sample();
        exp_jobs = 0;
        tests++;
        if (o !== idle_exp() || bus.job_cnt !== 8'd0) begin
            fails++;
            $display("[TB] FAIL areset_immediate: got %h cnt %0d expected %h cnt 0", o, bus.job_cnt, idle_exp());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < ACTIVE_LEN + 3; i++) begin
            tick();
            @(negedge clk);
            o = sample();
            tests++;
            if (o !== idle_exp()) begin
                fails++;
                $display("[TB] FAIL areset_no_result i=%0d: got %h expected %h", i, o, idle_exp());
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   jobs    = 0;
        int   last_hs = -1;
        int   budget  = 0;
        int   gap     = B2B ? 1 : 2;
        tick();
        bus.start_valid = 1'b1;
        bus.key_ready   = 1'b1;
        while (jobs < 256 && budget < 20000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            o = sample();
            if (o.load && last_hs >= 0) begin
                tests++;
                if (cyc - last_hs !== gap) begin
                    fails++;
                    $display("[TB] FAIL b2b_load_gap job %0d: got %0d cycles expected %0d", jobs, cyc - last_hs, gap);
                end
                last_hs = -1;
            end
            if (o.ov && bus.out_ready) begin
                jobs++;
                last_hs = cyc;
                tests++;
                if (bus.job_cnt !== 8'(jobs)) begin
                    fails++;
                    $display("[TB] FAIL b2b_job_cnt: got %0d expected %0d", bus.job_cnt, 8'(jobs));
                end
            end
            tick();
            budget++;
        end
        bus.start_valid = 1'b0;
        bus.out_ready   = 1'b0;
        tests++;
        if (jobs < 256) begin
            fails++;
            $display("[TB] FAIL b2b_timeout: got %0d jobs expected 256", jobs);
        end
        @(negedge clk);
        tests++;
        if (bus.job_cnt !== 8'd0) begin
            fails++;
            $display("[TB] FAIL b2b_wrap: got %0d expected 0", bus.job_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic();
        test_keywait();
        test_hold_stall();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
